// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU widths and the fetch-queue entry type
package cpu_defs;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  // One fetch-queue slot: the request address, the returned instruction,
  // and whether the instruction has come back yet.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch buffer with allocate, fill and pop pointers
module fetch_queue
  import cpu_defs::*;
#(
  parameter  int unsigned BUF_DEPTH = 2,
  localparam int unsigned PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             alloc_i,
  input  logic [XLEN-1:0]  alloc_pc_i,
  input  logic             fill_i,
  input  logic [ILEN-1:0]  fill_instr_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] unfilled_o
);

  fetch_entry_t     entries_q [BUF_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] unfilled_q, unfilled_d;
  logic             fill_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // unfilled_q only counts entries allocated in earlier cycles, so a response
  // can never land in a slot allocated this cycle; strays are ignored.
  assign fill_ok = fill_i && (unfilled_q != '0);

  // Pointer and occupancy next-state; a flush empties everything.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
    unfilled_d = unfilled_q + CNT_W'(alloc_i) - CNT_W'(fill_ok);
    if (alloc_i) tail_d = ptr_inc(tail_q);
    if (fill_ok) fill_d = ptr_inc(fill_q);
    if (pop_i)   head_d = ptr_inc(head_q);
    if (flush_i) begin
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
    end
  end

  // Entry storage; popped slots are zeroed so an empty queue reads 0.
  // Pop, alloc and fill always target distinct slots when they coincide.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      if (pop_i) entries_q[head_q] <= '0;
      if (alloc_i) entries_q[tail_q] <= '{pc: alloc_pc_i, instr: '0, filled: 1'b0};
      if (fill_ok) begin
        entries_q[fill_q].instr  <= fill_instr_i;
        entries_q[fill_q].filled <= 1'b1;
      end
    end
  end

  assign head_o     = entries_q[head_q];
  assign count_o    = count_q;
  assign unfilled_o = unfilled_q;

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction-fetch stage: issue, response drop on redirect, decode handshake
module fetch #(
  parameter int unsigned XLEN      = cpu_defs::XLEN,
  parameter int unsigned ILEN      = cpu_defs::ILEN,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            execute_i_is_jump,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_instr,
  output logic [XLEN-1:0] fetch_i_pre_pc,
  output logic            fetch_o_valid,
  output logic [ILEN-1:0] fetch_o_instr,
  output logic [XLEN-1:0] fetch_o_pc,
  output logic [XLEN-1:0] fetch_o_pre_pc,
  input  logic            decode_i_ready
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  cpu_defs::fetch_entry_t head;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       unfilled;
  logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
  logic                   accept;
  logic                   resp_drop;
  logic                   resp_fill;
  logic                   resp_legal;
  logic                   pop;

  // Outstanding requests are live entries plus responses still owed to a
  // flushed stream; both share the same BUF_DEPTH budget. No bypass: a full
  // queue blocks issue even in a cycle that pops.
  assign imem_req_valid = !rst && !execute_i_is_jump &&
                          (({1'b0, count} + {1'b0, drop_cnt_q}) < (CNT_W + 1)'(BUF_DEPTH));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign fetch_i_pre_pc = accept ? pc + XLEN'(cpu_defs::INSTR_BYTES) : pc;

  // A response belongs to the flushed stream while drop_cnt is nonzero.
  assign resp_drop  = imem_resp_valid && (drop_cnt_q != '0);
  assign resp_fill  = imem_resp_valid && (drop_cnt_q == '0) && !execute_i_is_jump;
  assign resp_legal = imem_resp_valid && ((drop_cnt_q != '0) || (unfilled != '0));

  assign fetch_o_valid  = !execute_i_is_jump && (count != '0) && head.filled;
  assign pop            = fetch_o_valid && decode_i_ready;
  assign fetch_o_instr  = head.instr;
  assign fetch_o_pc     = head.pc;
  assign fetch_o_pre_pc = (count != '0) ? head.pc + XLEN'(cpu_defs::INSTR_BYTES) : '0;

  // On redirect every unfilled entry becomes a response to discard; a
  // response arriving in the redirect cycle is itself discarded.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (execute_i_is_jump) begin
      drop_cnt_d = drop_cnt_q + unfilled;
      if (resp_legal) drop_cnt_d = drop_cnt_d - CNT_W'(1);
    end else if (resp_drop) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  // Discard counter register.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  fetch_queue #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (execute_i_is_jump),
    .alloc_i     (accept),
    .alloc_pc_i  (pc),
    .fill_i      (resp_fill),
    .fill_instr_i(imem_resp_instr),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .unfilled_o  (unfilled)
  );

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed self-checking bench for the fetch stage
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        jump;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic [63:0] pre_pc;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [63:0] o_pc;
  logic [63:0] o_pre_pc;
  logic        dec_ready;

  int          vectors     = 0;
  int          miscompares = 0;
  int          pops        = 0;
  logic [63:0] exp_pc      = '0;
  bit          auto_sb     = 1'b0;
  bit          mem_en      = 1'b1;
  logic [63:0] pend[$];

  always #5 clk = ~clk;

  fetch #(.XLEN(64), .ILEN(32), .BUF_DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .execute_i_is_jump(jump),
    .imem_req_valid   (req_valid),
    .imem_req_addr    (req_addr),
    .imem_req_ready   (req_ready),
    .imem_resp_valid  (resp_valid),
    .imem_resp_instr  (resp_instr),
    .fetch_i_pre_pc   (pre_pc),
    .fetch_o_valid    (o_valid),
    .fetch_o_instr    (o_instr),
    .fetch_o_pc       (o_pc),
    .fetch_o_pre_pc   (o_pre_pc),
    .decode_i_ready   (dec_ready)
  );

  function automatic logic [31:0] f(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample before the edge, then play pc register and 1-cycle memory.
  task automatic tick();
    logic        acc;
    logic [63:0] nxt;
    logic [63:0] addr;
    @(negedge clk);
    acc  = req_valid && req_ready;
    nxt  = pre_pc;
    addr = req_addr;
    if (auto_sb && o_valid === 1'b1 && dec_ready) begin
      chk("pop_pc", o_pc, exp_pc);
      chk("pop_instr", {32'h0, o_instr}, {32'h0, f(exp_pc)});
      chk("pop_pre_pc", o_pre_pc, exp_pc + 64'd4);
      exp_pc = exp_pc + 64'd4;
      pops++;
    end
    @(posedge clk);
    #1;
    pc = nxt;
    if (rst) begin
      pend.delete();
      resp_valid = 1'b0;
    end else begin
      if (acc === 1'b1) pend.push_back(addr);
      if (mem_en && pend.size() != 0) begin
        resp_valid = 1'b1;
        resp_instr = f(pend.pop_front());
      end else begin
        resp_valid = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input logic [63:0] start);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc  = start;
  endtask

  initial begin
    rst = 1'b1; pc = 64'h8000_0000; jump = 1'b0; req_ready = 1'b1;
    resp_valid = 1'b0; resp_instr = '0; dec_ready = 1'b1;
    tick(); tick(); #2;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_instr", o_instr, 0);
    chk("rst_o_pc", o_pc, 0);
    chk("rst_o_pre_pc", o_pre_pc, 0);
    chk("rst_pre_pc", pre_pc, 64'h8000_0000);

    // straight line: 2 instructions per 3 cycles
    rst = 1'b0; auto_sb = 1'b1; exp_pc = 64'h8000_0000; pops = 0;
    repeat (12) tick();
    #2;
    chk("line_pops", pops, 7);
    chk("line_pc", pc, 64'h8000_0020);

    // back-pressure for 5 cycles
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      chk("bp_valid", o_valid, 1);
      chk("bp_pc", o_pc, 64'h8000_001C);
      chk("bp_instr", o_instr, f(64'h8000_001C));
      chk("bp_req_valid", req_valid, 0);
      chk("bp_pre_pc", pre_pc, 64'h8000_0024);
    end
    dec_ready = 1'b1;
    repeat (6) tick();
    #2;
    chk("bp_pops", pops, 11);
    chk("bp_pc_after", pc, 64'h8000_0034);

    // flush with two unfilled requests outstanding
    auto_sb = 1'b0;
    do_reset(64'h1000);
    mem_en = 1'b0;
    tick(); tick(); #2;
    chk("fa_full", req_valid, 0);
    jump = 1'b1; #1;
    chk("fa_jump_o_valid", o_valid, 0);
    chk("fa_jump_req", req_valid, 0);
    chk("fa_jump_pre_pc", pre_pc, 64'h1008);
    tick();
    jump = 1'b0; pc = 64'h2000; #2;
    chk("fa_drop2_block", req_valid, 0);
    mem_en = 1'b1;
    tick(); #2;
    chk("fa_drop2_resp", req_valid, 0);
    tick(); #2;
    chk("fa_drop1_issue", req_valid, 1);
    auto_sb = 1'b1; exp_pc = 64'h2000; pops = 0;
    repeat (6) tick();
    #2;
    chk("fa_pops", pops, 3);

    // flush in the same cycle as a response
    auto_sb = 1'b0;
    do_reset(64'h3000);
    mem_en = 1'b0;
    tick();
    mem_en = 1'b1;
    tick();
    mem_en = 1'b0; jump = 1'b1; #2;
    chk("fb_jump_o_valid", o_valid, 0);
    tick();
    jump = 1'b0; pc = 64'h4000; mem_en = 1'b1;
    auto_sb = 1'b1; exp_pc = 64'h4000; pops = 0; #2;
    chk("fb_issue", req_valid, 1);
    tick(); #2;
    chk("fb_drop1_block", req_valid, 0);
    repeat (6) tick();
    #2;
    chk("fb_pops", pops, 3);

    // memory not ready for 3 cycles
    auto_sb = 1'b0;
    do_reset(64'h5000);
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nr_req_valid", req_valid, 1);
      chk("nr_pre_pc", pre_pc, 64'h5000);
      tick();
    end
    #1;
    chk("nr_o_valid", o_valid, 0);
    req_ready = 1'b1; auto_sb = 1'b1; exp_pc = 64'h5000; pops = 0;
    repeat (3) tick();
    #2;
    chk("nr_pops", pops, 1);
    chk("nr_pc", pc, 64'h5008);

    // reset mid-stream with two filled entries
    auto_sb = 1'b0;
    do_reset(64'h6000);
    dec_ready = 1'b0;
    repeat (3) tick();
    #2;
    chk("mr_o_valid", o_valid, 1);
    chk("mr_o_pc", o_pc, 64'h6000);
    rst = 1'b1; #1;
    chk("mr_rst_req", req_valid, 0);
    tick(); #2;
    chk("mr_o_valid0", o_valid, 0);
    chk("mr_o_instr0", o_instr, 0);
    chk("mr_o_pc0", o_pc, 0);
    chk("mr_o_pre_pc0", o_pre_pc, 0);
    chk("mr_req0", req_valid, 0);

    // address wrap
    pc = 64'hFFFF_FFFF_FFFF_FFFC; rst = 1'b0; dec_ready = 1'b1; #1;
    chk("wrap_req", req_valid, 1);
    chk("wrap_pre_pc", pre_pc, 0);
    auto_sb = 1'b1; exp_pc = 64'hFFFF_FFFF_FFFF_FFFC; pops = 0;
    repeat (3) tick();
    #2;
    chk("wrap_pops", pops, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
